// File: rtl/pwr_seq_timer.sv
// pwr_seq_timer: multi-channel power-up sequencer; each channel enable rises after its own delay.
// Optional power-good supervision (PGWAIT/FAULT states, pg input) is enabled by `define PWR_SEQ_PG_CHECK_EN.
module pwr_seq_timer #(
  parameter int               CH         = 4,
  parameter int               DW         = 32,
  parameter logic [CH*DW-1:0] DELAY      = {4{32'd80000000}},
  parameter bit               AUTO_START = 1'b1
`ifdef PWR_SEQ_PG_CHECK_EN
  ,
  parameter int               PG_TMO     = 1000000
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          off,
  input  logic          hold,
`ifdef PWR_SEQ_PG_CHECK_EN
  input  logic [CH-1:0] pg,
`endif
  output logic [CH-1:0] en,
  output logic [CH-1:0] en_n,
  output logic          busy,
  output logic          done,
  output logic [3:0]    stage,
  output logic          fault
);

`ifdef PWR_SEQ_PG_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_PGWAIT, S_FAULT} state_e;
  localparam logic [DW-1:0] TMO_LAST = (PG_TMO > 1) ? DW'(PG_TMO - 1) : '0;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
`endif

  localparam logic [3:0] LAST_STAGE = 4'(CH - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]    stage_q, stage_d;
  logic [CH-1:0] en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef PWR_SEQ_PG_CHECK_EN
  logic          fault_q, fault_d;
  logic          pgCur;
`endif

  logic [DW-1:0] curDly;
  logic [DW-1:0] dlyLast;
  logic [CH-1:0] stageHot;

  // Select the delay of the channel being timed; a zero delay behaves as one cycle.
  always_comb begin
    curDly   = '0;
    stageHot = '0;
    for (int k = 0; k < CH; k++) begin
      if (stage_q == 4'(k)) begin
        curDly      = DELAY[k*DW +: DW];
        stageHot[k] = 1'b1;
      end
    end
  end

  assign dlyLast = (curDly == '0) ? '0 : curDly - DW'(1);

`ifdef PWR_SEQ_PG_CHECK_EN
  assign pgCur = |(pg & stageHot);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    en_d    = en_q;
    done_d  = done_q;
`ifdef PWR_SEQ_PG_CHECK_EN
    fault_d = fault_q;
`endif
    if (off) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      stage_d = '0;
      en_d    = '0;
      done_d  = 1'b0;
`ifdef PWR_SEQ_PG_CHECK_EN
      fault_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_WAIT: begin
          if (!hold) begin
            if (cnt_q == dlyLast) begin
              cnt_d = '0;
              en_d  = en_q | stageHot;
`ifdef PWR_SEQ_PG_CHECK_EN
              state_d = S_PGWAIT;
`else
              if (stage_q == LAST_STAGE) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                stage_d = stage_q + 4'd1;
              end
`endif
            end else begin
              cnt_d = cnt_q + DW'(1);
            end
          end
        end
`ifdef PWR_SEQ_PG_CHECK_EN
        // The counter is reused here as the power-good timeout.
        S_PGWAIT: begin
          if (!hold) begin
            if (pgCur) begin
              cnt_d = '0;
              if (stage_q == LAST_STAGE) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = S_WAIT;
                stage_d = stage_q + 4'd1;
              end
            end else if (cnt_q == TMO_LAST) begin
              state_d = S_FAULT;
              cnt_d   = '0;
              en_d    = '0;
              fault_d = 1'b1;
            end else begin
              cnt_d = cnt_q + DW'(1);
            end
          end
        end
`endif
        default: begin
          if (start) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            stage_d = '0;
            en_d    = '0;
            done_d  = 1'b0;
`ifdef PWR_SEQ_PG_CHECK_EN
            fault_d = 1'b0;
`endif
          end
`ifdef PWR_SEQ_PG_CHECK_EN
          else if (state_q == S_DONE && !(&pg)) begin
            state_d = S_FAULT;
            en_d    = '0;
            done_d  = 1'b0;
            fault_d = 1'b1;
          end
`endif
        end
      endcase
    end
`ifdef PWR_SEQ_PG_CHECK_EN
    busy_d = (state_d == S_WAIT) || (state_d == S_PGWAIT);
`else
    busy_d = (state_d == S_WAIT);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= AUTO_START ? S_WAIT : S_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PWR_SEQ_PG_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PWR_SEQ_PG_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign en    = en_q;
  assign en_n  = ~en_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign stage = stage_q;
`ifdef PWR_SEQ_PG_CHECK_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pwr_seq_timer.sv
// tb_pwr_seq_timer: drives an auto-start and a start-triggered sequencer with shared inputs and
// compares both against a timestamp model (en[k] is high once active cycles reach the cumulative delay).
module tb_pwr_seq_timer;
  localparam int CH = 3;
  localparam int DW = 32;
  localparam logic [CH*DW-1:0] DELAY_A = {32'd3, 32'd5, 32'd10};
  localparam logic [CH*DW-1:0] DELAY_B = {32'd3, 32'd2, 32'd0};
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  logic rst, start, off, hold;
  logic [CH-1:0] enA, enNA, enB, enNB;
  logic busyA, doneA, faultA, busyB, doneB, faultB;
  logic [3:0] stageA, stageB;

  always #5 clk = ~clk;

  pwr_seq_timer #(.CH(CH), .DW(DW), .DELAY(DELAY_A), .AUTO_START(1'b1)) dutA (
    .clk(clk), .rst(rst), .start(start), .off(off), .hold(hold),
    .en(enA), .en_n(enNA), .busy(busyA), .done(doneA), .stage(stageA), .fault(faultA)
  );

  pwr_seq_timer #(.CH(CH), .DW(DW), .DELAY(DELAY_B), .AUTO_START(1'b0)) dutB (
    .clk(clk), .rst(rst), .start(start), .off(off), .hold(hold),
    .en(enB), .en_n(enNB), .busy(busyB), .done(doneB), .stage(stageB), .fault(faultB)
  );

  int checkCount = 0;
  int errorCount = 0;
  int dly [2][CH];
  int sumEnd [2][CH];
  int mode [2];
  int elapsed [2];
  bit afterEdge;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mode[0]    = M_RUN;
    mode[1]    = M_IDLE;
    elapsed[0] = 0;
    elapsed[1] = 0;
    afterEdge  = 1'b0;
  endtask

  // One clock edge of the model: only non-hold cycles in a running sequence advance time.
  task automatic modelEdge();
    for (int u = 0; u < 2; u++) begin
      if (off) begin
        mode[u]    = M_IDLE;
        elapsed[u] = 0;
      end else if (mode[u] != M_RUN) begin
        if (start) begin
          mode[u]    = M_RUN;
          elapsed[u] = 0;
        end
      end else if (!hold) begin
        elapsed[u]++;
        if (elapsed[u] >= sumEnd[u][CH-1]) mode[u] = M_DONE;
      end
    end
    afterEdge = 1'b1;
  endtask

  function automatic logic [CH-1:0] modelEn(input int u);
    logic [CH-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++)
      if (mode[u] != M_IDLE && elapsed[u] >= sumEnd[u][k]) r[k] = 1'b1;
    return r;
  endfunction

  function automatic int modelStage(input int u);
    int s;
    s = 0;
    if (mode[u] != M_IDLE)
      for (int k = 0; k < CH; k++)
        if (elapsed[u] >= sumEnd[u][k]) s++;
    return (s > CH - 1) ? CH - 1 : s;
  endfunction

  task automatic checkUnit(input string nm, input int u, input logic [CH-1:0] en, input logic [CH-1:0] enN,
                           input logic busy, input logic done, input logic [3:0] stage, input logic fault);
    logic [CH-1:0] expEn, expEnN;
    expEn  = modelEn(u);
    expEnN = ~expEn;
    checkOutput({nm, ".en"}, 32'(en), 32'(expEn));
    checkOutput({nm, ".en_n"}, 32'(enN), 32'(expEnN));
    checkOutput({nm, ".busy"}, 32'(busy), 32'(mode[u] == M_RUN && afterEdge));
    checkOutput({nm, ".done"}, 32'(done), 32'(mode[u] == M_DONE));
    checkOutput({nm, ".stage"}, 32'(stage), 32'(modelStage(u)));
    checkOutput({nm, ".fault"}, 32'(fault), 32'd0);
  endtask

  task automatic checkAll();
    checkUnit("A", 0, enA, enNA, busyA, doneA, stageA, faultA);
    checkUnit("B", 1, enB, enNB, busyB, doneB, stageB, faultB);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic s, input logic o, input logic h);
    start = s;
    off   = o;
    hold  = h;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst   = 1'b1;
    start = 1'b0;
    off   = 1'b0;
    hold  = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    off   = 1'b0;
    hold  = 1'b0;
    dly   = '{'{10, 5, 3}, '{0, 2, 3}};
    for (int u = 0; u < 2; u++) begin
      int s;
      s = 0;
      for (int k = 0; k < CH; k++) begin
        s += (dly[u][k] > 0) ? dly[u][k] : 1;
        sumEnd[u][k] = s;
      end
    end
    modelReset();
    @(negedge clk);
    checkAll();
    checkOutput("rst.enA", 32'(enA), 32'd0);
    checkOutput("rst.enNA", 32'(enNA), 32'd7);
    checkOutput("rst.stageA", 32'(stageA), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain auto-start sequence: 10, 15, 18
    for (int i = 1; i <= 18; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (i == 9)  checkOutput("t1.en@9", 32'(enA), 32'd0);
      if (i == 10) checkOutput("t1.en@10", 32'(enA), 32'd1);
      if (i == 14) checkOutput("t1.en@14", 32'(enA), 32'd1);
      if (i == 15) checkOutput("t1.en@15", 32'(enA), 32'd3);
      if (i == 17) checkOutput("t1.done@17", 32'(doneA), 32'd0);
      if (i == 18) begin
        checkOutput("t1.en@18", 32'(enA), 32'd7);
        checkOutput("t1.done@18", 32'(doneA), 32'd1);
        checkOutput("t1.enB", 32'(enB), 32'd0);
      end
    end

    // Four hold cycles during stage 1 push en[1] to 19 and en[2] to 22
    doReset();
    for (int i = 1; i <= 24; i++) begin
      applyStimulus(1'b0, 1'b0, (i >= 12 && i <= 15));
      if (i >= 12 && i <= 15) checkOutput("t2.stageHold", 32'(stageA), 32'd1);
      if (i == 18) checkOutput("t2.en@18", 32'(enA), 32'd1);
      if (i == 19) checkOutput("t2.en@19", 32'(enA), 32'd3);
      if (i == 21) checkOutput("t2.en@21", 32'(enA), 32'd3);
      if (i == 22) checkOutput("t2.done@22", 32'(doneA), 32'd1);
    end

    // Start-triggered unit with a zero delay on channel 0
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t3.enB@wait", 32'(enB), 32'd0);
    checkOutput("t3.busyB", 32'(busyB), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t3.enB@1", 32'(enB), 32'd1);
    checkOutput("t3.stageB@1", 32'(stageB), 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0);

    // off at cycle 12, start together with off, then a full restart
    doReset();
    for (int i = 1; i <= 12; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t4.en@12", 32'(enA), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4.offEn", 32'(enA), 32'd0);
    checkOutput("t4.offBusy", 32'(busyA), 32'd0);
    checkOutput("t4.offStage", 32'(stageA), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4.offStartBusy", 32'(busyA), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t4.idleBusy", 32'(busyA), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t4.restartBusy", 32'(busyA), 32'd1);
    for (int i = 1; i <= 18; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (i == 17) checkOutput("t4.done@17", 32'(doneA), 32'd0);
      if (i == 18) checkOutput("t4.en@18", 32'(enA), 32'd7);
    end

    // Asynchronous reset in the middle of the high phase at cycle 16
    doReset();
    for (int i = 1; i <= 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
    checkOutput("t5.preRst", 32'(enA), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    checkOutput("t5.asyncEn", 32'(enA), 32'd0);
    checkOutput("t5.asyncBusy", 32'(busyA), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (i == 10) checkOutput("t5.en@10", 32'(enA), 32'd1);
    end

    // Random mix of start, off, hold and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0)
        doReset();
      else
        applyStimulus($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/pwr_seq_timer.md
Name: pwr_seq_timer

Overview:
- Parametrised multi-channel power-up sequencer timer; successor to the single fixed-delay start-up flag generator.
- After reset, or on command, asserts CH enable outputs one after another, each after its own programmable cycle delay.
- Provides active-low copies, busy/done status, shutdown, pause and restart.
- Sits at top level, driving board regulator enables and internal "system ready" gating.

Parameters:
- CH, 4, number of sequenced channels (1..16)
- DW, 32, delay counter width in bits
- DELAY, {4{32'd80000000}}, packed CH*DW vector; channel k delay in bits [k*DW +: DW]
- AUTO_START, 1, 1 = sequence starts on its own after reset release; 0 = waits for start

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; begin or restart the sequence
- off  in  1  level; shut down all channels
- hold  in  1  level; pause the delay counter
- en  out  CH  channel enables, active-high
- en_n  out  CH  bitwise ~en
- busy  out  1  sequence in progress
- done  out  1  all CH channels enabled
- stage  out  4  index of the channel currently being timed
- fault  out  1  power-good timeout (PG_CHECK_EN only; otherwise tied 0)

Behaviour:
- Reset values: en=0, en_n=all ones, busy=0, done=0, stage=0, fault=0, counter=0.
- State after reset: WAIT if AUTO_START=1, else IDLE.
- All outputs are registered; en_n is derived from the en register, never separately timed.
- States:
  - IDLE: outputs off. start -> WAIT with stage=0 and counter=0.
  - WAIT: busy=1. counter increments each cycle hold=0. When counter == max(DELAY[stage],1)-1 and hold=0:
    - next edge sets en[stage] and clears counter.
    - if stage==CH-1 -> DONE, else stage increments.
  - DONE: busy=0, done=1, en all ones, stage holds CH-1.
  - FAULT: en=0, fault=1, busy=0 (PG_CHECK_EN only).
- Timing: a delay value of 0 is treated as 1.
  - en[k] rises exactly S_k cycles after the first WAIT cycle, where S_k = sum over i<=k of max(DELAY[i],1).
  - Each active hold cycle adds one cycle to this.
- hold:
  - Freezes counter, stage and state.
  - en bits already set stay set.
  - hold has no effect outside WAIT.
- start:
  - In IDLE, DONE or FAULT: clears en, done and fault; enters WAIT with stage=0 and counter=0 on the next edge.
  - Ignored in WAIT; no mid-sequence restart via start.
- off:
  - Highest priority below rst.
  - Next edge: en=0, done=0, busy=0, fault=0, stage=0, counter=0, state=IDLE.
  - While off=1, start is ignored. start and off in the same cycle: off wins.
- Counter width: DW bits, no wrap. The compare stops it at delay-1.
- Asserting rst mid-sequence: immediate return to reset values regardless of clk.
- On rst release with AUTO_START=1, the sequence restarts from stage 0.

Optional Feature:
- Macro PWR_SEQ_PG_CHECK_EN.
- When defined:
  - Adds input pg[CH-1:0] (power-good feedback) and parameter PG_TMO (default 1000000).
  - After en[k] is set and before timing stage k+1, the block waits in state PGWAIT for pg[k]=1.
  - If pg[k] is not seen within PG_TMO cycles -> FAULT.
  - In DONE, any pg bit dropping to 0 -> FAULT on the next edge.
  - Counter is reused for PGWAIT timing; hold also freezes PGWAIT.
- When undefined: no pg port, no PGWAIT or FAULT states, fault tied to 0.

Test Plan:
- CH=3, DELAY={3,5,10} (ch0=10), AUTO_START=1; release rst -> en[0] rises after 10 cycles, en[1] after 15, en[2] after 18; done=1 on the same edge as en[2]; en_n=~en at every cycle.
- Same config; hold=1 for 4 cycles during stage 1 -> en[1] at 19, en[2] at 22; stage holds 1 while hold=1.
- AUTO_START=0, DELAY ch0=0 -> idle with en=0 until start; start pulse -> en[0] rises 1 cycle after WAIT entry.
- off asserted at cycle 12 with en=3'b001 -> next edge en=0, busy=0, stage=0; start pulsed together with off -> remains IDLE; start after off falls -> full sequence again in 18 cycles.
- rst asserted asynchronously mid-clock at cycle 16 -> en=0 and busy=0 before the next clk edge; sequence restarts after release.
- PWR_SEQ_PG_CHECK_EN, PG_TMO=8, pg[1] never rises -> fault=1 and en=0 exactly 8 cycles after en[1] set; start then restarts the sequence with fault cleared.
